// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_loader_pkg;

  // Default geometry of the attached chain and the bitstream interface.
  localparam int CHAIN_LEN_DEF = 64;
  localparam int WORD_W_DEF    = 8;
  localparam int MCNT_W_DEF    = 16;

  // Loader operating phases; VERIFY is only reachable in the readback build.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    FIN    = 2'd3
  } ccff_state_e;

  // Width of a counter that must hold the value n itself (0..n).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word-to-bit serializer: a WORD_W shift buffer with a fill counter.
// Accepts a whole word when empty (or when its last bit leaves this cycle)
// and presents the buffered MSB as the current serial bit.
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              advance,
  output logic              can_load,
  output logic              bit_out,
  output logic              bit_valid
);

  localparam int FILL_W = cnt_width(WORD_W);

  logic [WORD_W-1:0] sreg_q;
  logic [FILL_W-1:0] fill_q;

  assign bit_valid = (fill_q != '0);
  assign bit_out   = sreg_q[WORD_W-1];
  // Refill is allowed in the same cycle the final buffered bit is consumed,
  // so a continuously valid source never sees a bubble between words.
  assign can_load  = !bit_valid || ((fill_q == FILL_W'(1)) && advance);

  // Buffer load / shift; a load always wins over the shift of the old word.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sreg_q <= '0;
      fill_q <= '0;
    end else if (load) begin
      sreg_q <= word;
      fill_q <= FILL_W'(WORD_W);
    end else if (advance && bit_valid) begin
      sreg_q <= sreg_q << 1;
      fill_q <= fill_q - FILL_W'(1);
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Writer end of the configuration chain: streams bitstream words MSB-first
// onto ccff_head and raises chain_shift_en on every cycle that carries a bit.
// Optional readback (macro CCFF_READBACK_EN): after the load a second pass
// recirculates the chain through ccff_tail and counts bits that differ from
// the re-supplied bitstream.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int WORD_W    = WORD_W_DEF,
  parameter int MCNT_W    = MCNT_W_DEF
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              chain_shift_en,
  output logic              busy,
  output logic              done,
  output logic [MCNT_W-1:0] mismatch_cnt
);

  localparam int              CNT_W    = cnt_width(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

  ccff_state_e      state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             head_q;
  logic             active;
  logic             ser_ready, ser_bit, ser_vld, ser_clr;
  logic             load_word;
  logic             final_shift;
  logic             head_bit;

  assign active         = (state_q == LOAD) || (state_q == VERIFY);
  assign chain_shift_en = active && ser_vld;
  // The shift that brings bit_cnt to CHAIN_LEN ends the pass; no further
  // word may be taken in that cycle and any leftover low bits are dropped.
  assign final_shift    = chain_shift_en && (bit_cnt_q == LAST_CNT);
  assign word_ready     = active && ser_ready && !final_shift;
  assign load_word      = word_valid && word_ready;
  assign ser_clr        = !active || final_shift;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == FIN);

  ccff_word_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .clk       (prog_clk),
    .rst       (pReset),
    .clr       (ser_clr),
    .load      (load_word),
    .word      (word_in),
    .advance   (chain_shift_en),
    .can_load  (ser_ready),
    .bit_out   (ser_bit),
    .bit_valid (ser_vld)
  );

`ifdef CCFF_READBACK_EN
  // During verify the chain is fed its own tail so contents survive the pass.
  assign head_bit = (state_q == VERIFY) ? ccff_tail : ser_bit;
`else
  assign head_bit = ser_bit;
`endif

  // Head holds its last driven value whenever the chain is not shifting.
  assign ccff_head = chain_shift_en ? head_bit : head_q;

  // State register.
  always_ff @(posedge prog_clk) begin
    if (pReset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; start is only honoured from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
`ifdef CCFF_READBACK_EN
      LOAD:    if (final_shift) state_d = VERIFY;
`else
      LOAD:    if (final_shift) state_d = FIN;
`endif
      VERIFY:  if (final_shift) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-pass shift counter, restarted at the end of each pass.
  always_ff @(posedge prog_clk) begin
    if (pReset)                       bit_cnt_q <= '0;
    else if (final_shift || !active)  bit_cnt_q <= '0;
    else if (chain_shift_en)          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
  end

  // Remember the last value put on ccff_head so stalls do not glitch it.
  always_ff @(posedge prog_clk) begin
    if (pReset) head_q <= 1'b0;
    else        head_q <= ccff_head;
  end

`ifdef CCFF_READBACK_EN
  localparam logic [MCNT_W-1:0] MCNT_MAX = '1;

  logic [MCNT_W-1:0] mcnt_q;
  logic              miss;

  // Expected bit comes from the re-supplied stream, observed bit from the tail.
  assign miss = (state_q == VERIFY) && chain_shift_en && (ccff_tail != ser_bit);

  // Saturating mismatch counter, cleared when a new operation starts.
  always_ff @(posedge prog_clk) begin
    if (pReset)                             mcnt_q <= '0;
    else if ((state_q == IDLE) && start)    mcnt_q <= '0;
    else if (miss && (mcnt_q != MCNT_MAX))  mcnt_q <= mcnt_q + MCNT_W'(1);
  end

  assign mismatch_cnt = mcnt_q;
`else
  logic unused_tail;

  assign unused_tail  = ccff_tail;
  assign mismatch_cnt = '0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader (10-bit chain, 8-bit words).
// Readback scenarios are compiled in when CCFF_READBACK_EN is defined.
module tb_ccff_chain_loader;

  localparam int CL = 10;
  localparam int WW = 8;
  localparam int MW = 2;
`ifdef CCFF_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int          HS_EXP    = RB ? 4 : 2;
  localparam int          SH_EXP    = RB ? 2 * CL : CL;
  localparam logic [CL-1:0] CHAIN_EXP = 10'b1010010111;

  logic          prog_clk = 1'b0;
  logic          pReset, start, word_valid, ccff_tail;
  logic [WW-1:0] word_in;
  logic          word_ready, ccff_head, chain_shift_en, busy, done;
  logic [MW-1:0] mismatch_cnt;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(
    .CHAIN_LEN (CL),
    .WORD_W    (WW),
    .MCNT_W    (MW)
  ) dut (
    .prog_clk       (prog_clk),
    .pReset         (pReset),
    .start          (start),
    .word_in        (word_in),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .ccff_head      (ccff_head),
    .ccff_tail      (ccff_tail),
    .chain_shift_en (chain_shift_en),
    .busy           (busy),
    .done           (done),
    .mismatch_cnt   (mismatch_cnt)
  );

  // Behavioural model of the attached chain, clocked only when enabled.
  logic [CL-1:0] chain = '0;
  logic          s_en = 1'b0, s_head = 1'b0;
  assign ccff_tail = chain[CL-1];
  always @(posedge prog_clk) if (s_en) chain <= {chain[CL-2:0], s_head};

  int   cmp_cnt = 0, err_cnt = 0;
  int   cyc = 0, hs_cnt = 0, done_cnt = 0, done_cyc = -1, pushed = 0;
  logic exp_q[$];
  logic obs_q[$];
  int   sh_cyc_q[$];

  // Monitor: sample mid-cycle, away from the active edge.
  always @(negedge prog_clk) begin
    cyc++;
    s_en   = chain_shift_en;
    s_head = ccff_head;
    if (chain_shift_en === 1'b1) begin
      obs_q.push_back(ccff_head);
      sh_cyc_q.push_back(cyc);
    end
    if (word_valid === 1'b1 && word_ready === 1'b1) hs_cnt++;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_mon();
    exp_q.delete(); obs_q.delete(); sh_cyc_q.delete();
    hs_cnt = 0; done_cnt = 0; done_cyc = -1; pushed = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
  endtask

  // Offer one word until accepted; load-phase words feed the scoreboard.
  task automatic feed(input logic [WW-1:0] w, input int idle, input bit verify);
    bit ok = 1'b0;
    word_in = w; word_valid = 1'b1;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge prog_clk);
      if (word_ready === 1'b1) ok = 1'b1;
      @(posedge prog_clk); #1;
    end
    word_valid = 1'b0;
    cmp_cnt++;
    if (!ok) begin
      err_cnt++;
      $display("FAIL handshake_timeout: word %h accepted=0 required=1", w);
    end
    if (ok && !verify)
      for (int i = WW - 1; i >= 0; i--)
        if (pushed < CL) begin exp_q.push_back(w[i]); pushed++; end
    repeat (idle) begin @(posedge prog_clk); #1; end
  endtask

  // One full operation; a surplus word is offered afterwards and must be refused.
  task automatic run_op(input logic [WW-1:0] w0, input logic [WW-1:0] w1, input int idle,
                        input bit mid_start, input logic [WW-1:0] v0, input logic [WW-1:0] v1);
    int c;
    clear_mon();
    pulse_start();
    feed(w0, idle, 1'b0);
    if (mid_start) pulse_start();
    feed(w1, 0, 1'b0);
    if (RB) begin
      feed(v0, 0, 1'b1);
      feed(v1, 0, 1'b1);
    end
    word_in = 8'hFF; word_valid = 1'b1;
    for (c = 0; c < 300 && done_cnt == 0; c++) @(negedge prog_clk);
    cmp_cnt++;
    if (done_cnt == 0) begin
      err_cnt++;
      $display("FAIL done_timeout: done seen=0 required=1");
    end
    repeat (4) @(posedge prog_clk);
    #1 word_valid = 1'b0;
  endtask

  task automatic test_reset();
    pReset = 1'b1; start = 1'b0; word_valid = 1'b0; word_in = '0;
    repeat (3) @(posedge prog_clk);
    #1 pReset = 1'b0;
    @(negedge prog_clk);
    cmp_cnt++;
    if ({word_ready, ccff_head, chain_shift_en, busy, done, mismatch_cnt} !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: rdy/head/en/busy/done/mcnt=%b%b%b%b%b/%0d required all 0",
               word_ready, ccff_head, chain_shift_en, busy, done, mismatch_cnt);
    end
    @(posedge prog_clk); #1;
  endtask

  task automatic test_back_to_back();
    logic e, o;
    int   gap;
    run_op(8'hA5, 8'hC0, 0, 1'b0, 8'hA5, 8'hC0);
    for (int i = 0; i < CL; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      cmp_cnt++;
      if (o !== e) begin err_cnt++; $display("FAIL b2b_bit%0d: head=%b required=%b", i, o, e); end
    end
    gap = (sh_cyc_q.size() >= CL) ? sh_cyc_q[CL-1] - sh_cyc_q[0] + 1 - CL : -1;
    cmp_cnt++;
    if (gap != 0) begin err_cnt++; $display("FAIL b2b_gap: en-low cycles=%0d required=0", gap); end
    cmp_cnt++;
    if (hs_cnt != HS_EXP) begin err_cnt++; $display("FAIL b2b_hs: handshakes=%0d required=%0d", hs_cnt, HS_EXP); end
    cmp_cnt++;
    if (sh_cyc_q.size() != SH_EXP) begin
      err_cnt++; $display("FAIL b2b_shifts: shifts=%0d required=%0d", sh_cyc_q.size(), SH_EXP);
    end
    cmp_cnt++;
    if (done_cnt != 1) begin err_cnt++; $display("FAIL b2b_done_cnt: done pulses=%0d required=1", done_cnt); end
    cmp_cnt++;
    if (sh_cyc_q.size() == 0 || done_cyc != sh_cyc_q[$] + 1) begin
      err_cnt++; $display("FAIL b2b_done_time: done cycle=%0d required last shift+1", done_cyc);
    end
    cmp_cnt++;
    if (chain !== CHAIN_EXP) begin err_cnt++; $display("FAIL b2b_chain: chain=%b required=%b", chain, CHAIN_EXP); end
    cmp_cnt++;
    if (busy !== 1'b0 || mismatch_cnt !== '0) begin
      err_cnt++; $display("FAIL b2b_idle: busy=%b mcnt=%0d required 0/0", busy, mismatch_cnt);
    end
  endtask

  task automatic test_stall_gap();
    logic e, o;
    int   gap;
    chain = '0;
    run_op(8'hA5, 8'hC0, WW + 3 - 1, 1'b0, 8'hA5, 8'hC0);
    for (int i = 0; i < CL; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      cmp_cnt++;
      if (o !== e) begin err_cnt++; $display("FAIL gap_bit%0d: head=%b required=%b", i, o, e); end
    end
    gap = (sh_cyc_q.size() >= CL) ? sh_cyc_q[CL-1] - sh_cyc_q[0] + 1 - CL : -1;
    cmp_cnt++;
    if (gap != 3) begin err_cnt++; $display("FAIL gap_len: en-low cycles=%0d required=3", gap); end
    cmp_cnt++;
    if (chain !== CHAIN_EXP) begin err_cnt++; $display("FAIL gap_chain: chain=%b required=%b", chain, CHAIN_EXP); end
  endtask

  task automatic test_mid_reset();
    logic e, o;
    int   c;
    chain = '0;
    clear_mon();
    pulse_start();
    feed(8'hA5, 0, 1'b0);
    for (c = 0; c < 50 && sh_cyc_q.size() < 5; c++) @(negedge prog_clk);
    @(posedge prog_clk); #1;
    pReset = 1'b1; start = 1'b1;
    @(posedge prog_clk); #1;
    pReset = 1'b0; start = 1'b0;
    @(negedge prog_clk);
    cmp_cnt++;
    if ({word_ready, ccff_head, chain_shift_en, busy, done, mismatch_cnt} !== '0) begin
      err_cnt++;
      $display("FAIL midrst_outputs: rdy/head/en/busy/done/mcnt=%b%b%b%b%b/%0d required all 0",
               word_ready, ccff_head, chain_shift_en, busy, done, mismatch_cnt);
    end
    repeat (2) @(negedge prog_clk);
    cmp_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL midrst_start_ignored: busy=%b required=0", busy); end
    @(posedge prog_clk); #1;
    run_op(8'hA5, 8'hC0, 0, 1'b0, 8'hA5, 8'hC0);
    for (int i = 0; i < CL; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      cmp_cnt++;
      if (o !== e) begin err_cnt++; $display("FAIL reload_bit%0d: head=%b required=%b", i, o, e); end
    end
    cmp_cnt++;
    if (chain !== CHAIN_EXP) begin err_cnt++; $display("FAIL reload_chain: chain=%b required=%b", chain, CHAIN_EXP); end
  endtask

  task automatic test_start_while_busy();
    logic e, o;
    run_op(8'h3C, 8'h81, 0, 1'b1, 8'h3C, 8'h81);
    for (int i = 0; i < CL; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      cmp_cnt++;
      if (o !== e) begin err_cnt++; $display("FAIL busy_start_bit%0d: head=%b required=%b", i, o, e); end
    end
    cmp_cnt++;
    if (done_cnt != 1) begin err_cnt++; $display("FAIL busy_start_done: done pulses=%0d required=1", done_cnt); end
    cmp_cnt++;
    if (hs_cnt != HS_EXP) begin err_cnt++; $display("FAIL busy_start_hs: handshakes=%0d required=%0d", hs_cnt, HS_EXP); end
    cmp_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL busy_start_idle: busy=%b required=0", busy); end
  endtask

`ifdef CCFF_READBACK_EN
  task automatic test_readback();
    chain = '0;
    run_op(8'hA5, 8'hC0, 0, 1'b0, 8'hA5, 8'hC0);
    cmp_cnt++;
    if (mismatch_cnt !== 2'd0) begin err_cnt++; $display("FAIL rb_clean: mcnt=%0d required=0", mismatch_cnt); end
    cmp_cnt++;
    if (chain !== CHAIN_EXP) begin err_cnt++; $display("FAIL rb_chain: chain=%b required=%b", chain, CHAIN_EXP); end
    run_op(8'hA5, 8'hC0, 0, 1'b0, 8'hAD, 8'hC0);
    cmp_cnt++;
    if (mismatch_cnt !== 2'd1) begin err_cnt++; $display("FAIL rb_flip3: mcnt=%0d required=1", mismatch_cnt); end
    run_op(8'hA5, 8'hC0, 0, 1'b0, 8'h5A, 8'h3F);
    cmp_cnt++;
    if (mismatch_cnt !== 2'd3) begin err_cnt++; $display("FAIL rb_saturate: mcnt=%0d required=3", mismatch_cnt); end
    cmp_cnt++;
    if (chain !== CHAIN_EXP) begin err_cnt++; $display("FAIL rb_chain_kept: chain=%b required=%b", chain, CHAIN_EXP); end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_stall_gap();
    test_mid_reset();
    test_start_while_busy();
`ifdef CCFF_READBACK_EN
    test_readback();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
